seq_alu: RTL

- Parametrised, handshaked, multi-cycle successor to the single-cycle datapath ALU, using the same operation codes and status-bit layout.
- Single-cycle ops (add/sub/address calc/logic/slt/shift) complete in 1 cycle.
- Multiply and divide run iteratively over WIDTH cycles on a shared shift-add/shift-subtract datapath.
- Sits between the decode/issue stage and writeback; valid/ready on both sides allows stalling.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/seq_alu_if.sv | 25 ++
 rtl/alu_muldiv_iter.sv | 111 +++++++++++
 rtl/seq_alu.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, status bit positions,
// FSM state encoding and the status-byte packing helper.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_DIVU = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_LH   = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam int unsigned ST_ZERO    = 7;
  localparam int unsigned ST_OVF     = 6;
  localparam int unsigned ST_CARRY   = 5;
  localparam int unsigned ST_NEG     = 4;
  localparam int unsigned ST_INVADDR = 3;
  localparam int unsigned ST_DIVZ    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  function automatic logic [7:0] pack_status(input logic zero, input logic ovf,
                                             input logic carry, input logic neg,
                                             input logic inv_addr, input logic divz);
    logic [7:0] s;
    s             = '0;
    s[ST_ZERO]    = zero;
    s[ST_OVF]     = ovf;
    s[ST_CARRY]   = carry;
    s[ST_NEG]     = neg;
    s[ST_INVADDR] = inv_addr;
    s[ST_DIVZ]    = divz;
    return s;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between issue, the ALU and writeback.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_operand_1;
  logic [WIDTH-1:0] alu_operand_2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_result_hi;
  logic [7:0]       alu_status;

  modport master (
    output in_valid, alu_control, alu_operand_1, alu_operand_2, out_ready,
    input  in_ready, out_valid, alu_result, alu_result_hi, alu_status
  );

  modport slave (
    input  in_valid, alu_control, alu_operand_1, alu_operand_2, out_ready,
    output in_ready, out_valid, alu_result, alu_result_hi, alu_status
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring shift-subtract)
// sharing one adder and one {hi,lo} shift register; iteration 0 runs on start.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_mode_e         mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  md_mode_e         mode_q, mode_d;

  logic [WIDTH-1:0] cur_lo, cur_hi, cur_opnd;
  md_mode_e         cur_mode;
  logic [WIDTH:0]   add_a, add_b;
  logic             add_cin;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] step_lo, step_hi;

  // Shared adder: mul adds the multiplicand, div subtracts the divisor (top bit = no borrow)
  always_comb begin
    cur_lo   = start ? op_a : lo_q;
    cur_hi   = start ? '0   : hi_q;
    cur_opnd = start ? op_b : opnd_q;
    cur_mode = start ? mode : mode_q;
    if (cur_mode == MD_MUL) begin
      add_a   = {1'b0, cur_hi};
      add_b   = cur_lo[0] ? {1'b0, cur_opnd} : '0;
      add_cin = 1'b0;
    end else begin
      add_a   = {cur_hi, cur_lo[WIDTH-1]};
      add_b   = ~{1'b0, cur_opnd};
      add_cin = 1'b1;
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(add_cin);
    if (cur_mode == MD_MUL) begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], cur_lo[WIDTH-1:1]};
    end else if (sum[WIDTH+1]) begin
      step_hi = sum[WIDTH-1:0];
      step_lo = {cur_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = add_a[WIDTH-1:0];
      step_lo = {cur_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    opnd_d = opnd_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      lo_d   = step_lo;
      hi_d   = step_hi;
      opnd_d = cur_opnd;
      mode_d = cur_mode;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      lo_d  = step_lo;
      hi_d  = step_hi;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 2)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q   <= '0;
      hi_q   <= '0;
      opnd_q <= '0;
      mode_q <= MD_MUL;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      opnd_q <= opnd_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle ops resolve on accept, mul/divu
// run on the iterative unit; results and flags are held until out_ready.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     reset,
  seq_alu_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic [7:0]       status_q, status_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] sc_b, sc_res, sc_hi;
  logic [WIDTH:0]   sum;
  logic             sc_ovf, sc_inv, sc_carry, sc_divz, sc_defined;
  logic [7:0]       sc_status;

  logic             md_start, md_done;
  md_mode_e         md_mode;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign op = bus.alu_control;
  assign a  = bus.alu_operand_1;
  assign b  = bus.alu_operand_2;

  // Single-cycle results and flags, evaluated straight from the request
  always_comb begin
    sc_b       = (op == ALU_SUB) ? ((~b) + WIDTH'(1)) : b;
    sum        = {1'b0, a} + {1'b0, sc_b};
    sc_ovf     = ((op == ALU_ADD) || (op == ALU_SUB)) &&
                 (a[WIDTH-1] == sc_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sc_inv     = ((op == ALU_LW) && (sum[1:0] != 2'b00)) || ((op == ALU_LH) && sum[0]);
    sc_carry   = 1'b0;
    sc_divz    = 1'b0;
    sc_defined = 1'b1;
    sc_res     = '0;
    sc_hi      = '0;
    case (op)
      ALU_AND: sc_res = a & b;
      ALU_OR:  sc_res = a | b;
      ALU_NOR: sc_res = ~(a | b);
      ALU_ADD, ALU_SUB, ALU_LW, ALU_LH: begin
        sc_carry = sum[WIDTH] && !sc_ovf && !sc_inv;
        sc_res   = (sc_ovf || sc_inv) ? '0 : sum[WIDTH-1:0];
      end
      ALU_DIVU: begin
        sc_divz = 1'b1;
        sc_hi   = a;
      end
      ALU_SLT: sc_res = WIDTH'($signed(a) < $signed(b));
      ALU_SLL: sc_res = b << a[SHAMT_W-1:0];
      ALU_SRL: sc_res = b >> a[SHAMT_W-1:0];
      default: sc_defined = 1'b0;
    endcase
    sc_status = sc_defined ?
      pack_status((sc_res == '0) && !sc_ovf && !sc_inv && !sc_divz,
                  sc_ovf, sc_carry, sc_res[WIDTH-1], sc_inv, sc_divz) : '0;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    status_d    = status_q;
    md_start    = 1'b0;
    md_mode     = MD_MUL;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (op == ALU_MUL) begin
            md_start = 1'b1;
            md_mode  = MD_MUL;
            state_d  = MUL;
          end else if ((op == ALU_DIVU) && (b != '0)) begin
            md_start = 1'b1;
            md_mode  = MD_DIV;
            state_d  = DIV;
          end else begin
            state_d     = DONE;
            result_d    = sc_res;
            result_hi_d = sc_hi;
            status_d    = sc_status;
          end
        end
      end
      MUL, DIV: begin
        if (md_done) begin
          state_d     = DONE;
          result_d    = md_lo;
          result_hi_d = md_hi;
          status_d    = pack_status(md_lo == '0, 1'b0, 1'b0, md_lo[WIDTH-1], 1'b0, 1'b0);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      status_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      status_q    <= status_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .mode  (md_mode),
    .op_a  (a),
    .op_b  (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.alu_result    = result_q;
  assign bus.alu_result_hi = result_hi_q;
  assign bus.alu_status    = status_q;

endmodule
